priority_demux: RTL
===================

Name: priority_demux

Overview:
- Registered priority demultiplexer: routes one input word to exactly one of N_OUT output channels.
- Destination is the lowest-index set bit of i_ctrl. Bit 0 has highest priority; if no bit is set, the word is dropped.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Sits at the distribution end of the decision-tree datapath: it fans a selected stream back out to per-lane consumers.

Parameters:
- WIDTH, 1, data word width in bits.
- N_OUT, 4, number of output channels; must be >= 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_in  input  WIDTH  input data word.
- i_ctrl  input  N_OUT  destination select; priority-resolved, LSB wins.
- i_valid  input  1  input word and i_ctrl valid this cycle.
- o_ready  output  1  block accepts the input this cycle.
- o_out  output  N_OUT*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- o_valid  output  N_OUT  per-channel data valid.
- i_ready  input  N_OUT  per-channel consumer ready.

Behaviour:
- Reset, sampled on rising i_clk while i_rst_n=0:
  - all o_valid=0 and all o_out=0;
  - drop counter (if present)=0.
  - Reset overrides any transfer in the same cycle; words held in buffers are discarded.
- Destination select: sel = one-hot of the lowest set bit of i_ctrl; sel=0 when i_ctrl=0.
  - Example: i_ctrl=4'b0110 -> channel 1.
- Acceptance is purely combinational from current state and inputs:
  - o_ready = (sel==0), or the selected buffer is empty, or the selected buffer is being drained this cycle (o_valid[k] & i_ready[k]).
  - o_ready is valid regardless of i_valid.
- Transfer = i_valid & o_ready.
  - If sel!=0: the word is written into buffer k.
  - o_valid[k]=1 and o_out lane k=i_in on the next cycle. Latency is 1 cycle.
- Drain: when o_valid[k] & i_ready[k], buffer k empties next cycle unless refilled in the same cycle.
  - A simultaneous drain and fill of the same channel gives back-to-back throughput: o_valid stays 1 and data updates.
- A stalled channel blocks only inputs addressed to it. Other channels continue draining independently.
- o_out lane k holds its last value while o_valid[k]=0; it is not cleared.
- Drop: i_valid=1 with i_ctrl=0 is accepted (o_ready=1) and discarded; no output changes.
- Input stability: if i_valid=1 and o_ready=0, upstream holds i_in and i_ctrl stable until transfer.
- No combinational path exists from i_in to o_out.

Optional Feature:
- Macro: PRIORITY_DEMUX_DROPCNT_EN.
- Defined:
  - Adds output port o_drop_count, 8 bits.
  - Increments by 1 on each dropped transfer (i_valid=1, i_ctrl=0), saturating at 8'hFF.
  - Reset value 0; value visible the cycle after the drop.
- Undefined:
  - No port and no counter logic.
  - Drops are silent; all other behaviour is identical.

Decomposition:
- Package priority_demux_pkg:
  - localparam defaults for WIDTH and N_OUT;
  - function lowest_set_onehot(ctrl) returning the priority-resolved one-hot select;
  - localparam DROPCNT_W=8.
- Sub-module demux_slot: one-entry holding register per channel.
  - Inputs: fill, data, drain.
  - Outputs: valid, data, can_accept.
  - Instantiated N_OUT times in a generate loop.
- Top level holds the priority select, o_ready, and the optional drop counter.

Test Plan:
- Reset mid-operation: fill channels 0 and 2, assert i_rst_n=0 for 1 cycle -> o_valid=4'b0000 and o_out=0 next cycle; no stale data reappears.
- Priority: i_ctrl=4'b1010, i_in=1, i_valid=1, all i_ready=1 -> next cycle o_valid=4'b0010 and lane 1=1; lane 3 untouched.
- Backpressure: i_ready[2]=0, send two words with i_ctrl=4'b0100 -> first accepted; o_ready=0 for the second until i_ready[2]=1, then the second is accepted in the drain cycle with no bubble.
- Independent lanes: channel 0 stalled and full, send i_ctrl=4'b0010 -> o_ready=1, word delivered on channel 1 one cycle later.
- Drop: i_ctrl=0, i_valid=1 for 3 cycles -> o_ready=1 and no o_valid change; with PRIORITY_DEMUX_DROPCNT_EN, o_drop_count=3. After 300 drops it holds at 255.
- Streaming: all i_ready=1, i_ctrl rotating 1,2,4,8 each cycle with i_valid=1 -> o_ready constantly 1; each channel shows the expected word exactly 1 cycle after input.

Source files
------------

// File: rtl/priority_demux_pkg.sv
// Shared constants and the priority-resolution helper for priority_demux.
package priority_demux_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_N_OUT = 4;
    localparam int MAX_N_OUT     = 32;
    localparam int DROPCNT_W     = 8;

    // x & -x isolates the lowest set bit; zero stays zero.
    function automatic logic [MAX_N_OUT-1:0] lowest_set_onehot(input logic [MAX_N_OUT-1:0] ctrl);
        return ctrl & (~ctrl + {{(MAX_N_OUT-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/priority_demux_slot.sv
// One-entry holding register for a single output channel of priority_demux.
module demux_slot #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            data_reg  <= fill_data;
        end else if (valid_reg && drain) begin
            // Data is kept after draining; only the valid flag drops.
            valid_reg <= 1'b0;
        end
    end

    assign can_accept = !valid_reg || drain;
    assign valid      = valid_reg;
    assign data       = data_reg;

endmodule

// File: rtl/priority_demux.sv
// Registered priority demultiplexer: lowest set i_ctrl bit picks the output channel.
// Optional drop counter enabled by defining PRIORITY_DEMUX_DROPCNT_EN.
module priority_demux
    import priority_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_OUT = DEFAULT_N_OUT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_in,
    input  logic [N_OUT-1:0]       i_ctrl,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [N_OUT*WIDTH-1:0] o_out,
    output logic [N_OUT-1:0]       o_valid,
    input  logic [N_OUT-1:0]       i_ready
`ifdef PRIORITY_DEMUX_DROPCNT_EN
    ,
    output logic [DROPCNT_W-1:0]   o_drop_count
`endif
);

    logic [N_OUT-1:0] sel;
    logic [N_OUT-1:0] slot_accept;
    logic [N_OUT-1:0] fill;
    logic             transfer;

    assign sel      = N_OUT'(lowest_set_onehot(MAX_N_OUT'(i_ctrl)));
    assign o_ready  = (sel == '0) || ((sel & slot_accept) != '0);
    assign transfer = i_valid && o_ready;
    assign fill     = {N_OUT{transfer}} & sel;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
            demux_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .fill       (fill[gi]),
                .fill_data  (i_in),
                .drain      (i_ready[gi]),
                .valid      (o_valid[gi]),
                .data       (o_out[gi*WIDTH +: WIDTH]),
                .can_accept (slot_accept[gi])
            );
        end
    endgenerate

`ifdef PRIORITY_DEMUX_DROPCNT_EN
    logic [DROPCNT_W-1:0] drop_count_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drop_count_reg <= '0;
        end else if (transfer && (sel == '0) && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    assign o_drop_count = drop_count_reg;
`endif

endmodule
